// File: rtl/add_sub_arbiter.sv
// Two-requester round-robin arbiter in front of a shared adder/subtractor/comparator.
// Each operation goes through IDLE -> EXEC -> RESP. The result is held in RESP until
// the owning requester accepts it.
// Optional build macro ADDSUB_ARB_FASTPATH_EN: when defined, a new request may be
// accepted in the same cycle that a response is taken, so the FSM goes RESP -> EXEC.
// That gives two cycles per op instead of three.

module add_sub_comp #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub_sel,
  input  logic              unsigned_sel,
  output logic [DATA_W-1:0] result,
  output logic              less,
  output logic              equal
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] b_eff;
  logic              ovf;

  // Single carry-propagate adder: a + ~b + 1 for subtraction.
  // The comparison flags are only meaningful when sub_sel is high.
  always_comb begin
    b_eff  = b ^ {DATA_W{sub_sel}};
    sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_sel};
    result = sum[DATA_W-1:0];
    ovf    = (a[DATA_W-1] == b_eff[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
    // A carry out of a - b means a >= b (unsigned). For signed, use N xor V.
    less   = unsigned_sel ? ~sum[DATA_W] : (result[DATA_W-1] ^ ovf);
    equal  = (result == '0);
  end

endmodule

module add_sub_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data
);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpSlt  = 3'b010;
  localparam logic [2:0] OpSltu = 3'b011;
  localparam logic [2:0] OpEq   = 3'b100;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;

  logic              win;
  logic              any_valid;
  logic              owner_rsp_ready;
  logic              accept_window;
  logic              accept;
  logic              cmp_sub_sel;
  logic              cmp_unsigned_sel;
  logic [DATA_W-1:0] cmp_result;
  logic              cmp_less;
  logic              cmp_equal;
  logic [DATA_W-1:0] exec_result;

  // Arbitration: a lone requester wins; under contention the one not granted last wins.
  always_comb begin
    any_valid       = req0_valid | req1_valid;
    win             = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
`ifdef ADDSUB_ARB_FASTPATH_EN
    accept_window   = (state_q == StIdle) || ((state_q == StResp) && owner_rsp_ready);
`else
    accept_window   = (state_q == StIdle);
`endif
    // rst_n gating keeps ready low during reset even though the FSM already sits in IDLE.
    accept          = accept_window & any_valid & rst_n;
    req0_ready      = accept & ~win;
    req1_ready      = accept & win;
  end

  add_sub_comp #(
    .DATA_W (DATA_W)
  ) u_add_sub_comp (
    .a            (a_q),
    .b            (b_q),
    .sub_sel      (cmp_sub_sel),
    .unsigned_sel (cmp_unsigned_sel),
    .result       (cmp_result),
    .less         (cmp_less),
    .equal        (cmp_equal)
  );

  // Decode the registered opcode into comparator controls and the result mapping.
  always_comb begin
    cmp_sub_sel      = (op_q != OpAdd);
    cmp_unsigned_sel = (op_q == OpSltu);
    unique case (op_q)
      OpAdd, OpSub:  exec_result = cmp_result;
      OpSlt, OpSltu: exec_result = {{(DATA_W-1){1'b0}}, cmp_less};
      OpEq:          exec_result = {{(DATA_W-1){1'b0}}, cmp_equal};
      default:       exec_result = '0;
    endcase
  end

  // Next-state logic: capture on accept, compute in EXEC, hold response in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_data_d  = exec_result;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_data_d  = exec_result;
        end
        state_d = StResp;
      end
      StResp: begin
        // The non-owner's rsp_ready never reaches here.
        if (owner_rsp_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = accept ? StExec : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture is shared by IDLE and by the RESP fast path.
    if (accept) begin
      last_grant_d = win;
      owner_d      = win;
      op_d         = win ? req1_op : req0_op;
      a_d          = win ? req1_a  : req0_a;
      b_d          = win ? req1_b  : req0_b;
    end
  end

  // State and datapath registers. Reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Self-checking bench for add_sub_arbiter: transaction-level reference model plus
// directed literal cases, then randomized traffic. Honours ADDSUB_ARB_FASTPATH_EN.

module tb_add_sub_arbiter;

  localparam int W = 32;
`ifdef ADDSUB_ARB_FASTPATH_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   rsp_ready;
  logic [2:0]   req_op [2];
  logic [W-1:0] req_a [2];
  logic [W-1:0] req_b [2];
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_data, rsp1_data;

  add_sub_arbiter #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req_valid[0]),
    .req0_ready (req0_ready),
    .req0_op    (req_op[0]),
    .req0_a     (req_a[0]),
    .req0_b     (req_b[0]),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp_ready[0]),
    .rsp0_data  (rsp0_data),
    .req1_valid (req_valid[1]),
    .req1_ready (req1_ready),
    .req1_op    (req_op[1]),
    .req1_a     (req_a[1]),
    .req1_b     (req_b[1]),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp_ready[1]),
    .rsp1_data  (rsp1_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, got no event, expected one (cycle %0d)", nm, cyc);
  endtask

  // Result of an operation, straight from the opcode table.
  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3:    return (a < b) ? 1 : 0;
      3'd4:    return (a == b) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  // Transaction model: one job in flight, age 1 = computing, age >= 2 = response offered.
  bit           m_busy = 0;
  int           m_owner = 0;
  int           m_age = 0;
  int           m_last = 1;
  logic [W-1:0] m_res = '0;

  // Observations consumed by the directed sections.
  bit           acc_pend [2] = '{0, 0};
  int           acc_cyc [2] = '{0, 0};
  int           hs_cnt [2] = '{0, 0};
  int           hs_cyc [2] = '{0, 0};
  logic [W-1:0] hs_data [2];
  int           order [$];
  int           hs0_q [$];
  int           rsp_seen = 0;

  // Compare DUT against the model each cycle, then advance the model past the next edge.
  always @(negedge clk) begin
    logic [1:0]   act_rdy, act_v, exp_rdy, exp_v;
    logic [W-1:0] act_d [2];
    bit           can;
    act_rdy = {req1_ready, req0_ready};
    act_v   = {rsp1_valid, rsp0_valid};
    act_d[0] = rsp0_data;
    act_d[1] = rsp1_data;
    if (!rst_n) begin
      check("rst_req_ready", W'(act_rdy), '0);
      check("rst_rsp_valid", W'(act_v), '0);
      check("rst_rsp0_data", rsp0_data, '0);
      check("rst_rsp1_data", rsp1_data, '0);
      m_busy = 0;
      m_last = 1;
    end else begin
      can = !m_busy || (Fast && m_age >= 2 && rsp_ready[m_owner]);
      for (int k = 0; k < 2; k++) begin
        exp_rdy[k] = can && req_valid[k] && (!(&req_valid) || m_last != k);
        exp_v[k]   = m_busy && m_owner == k && m_age >= 2;
      end
      check("req_ready", W'(act_rdy), W'(exp_rdy));
      check("rsp_valid", W'(act_v), W'(exp_v));
      for (int k = 0; k < 2; k++) begin
        if (exp_v[k]) check(k == 0 ? "rsp0_data" : "rsp1_data", act_d[k], m_res);
      end
      if (act_v != 0) rsp_seen++;
      for (int k = 0; k < 2; k++) begin
        if (act_rdy[k]) begin
          acc_pend[k] = 1;
          acc_cyc[k]  = cyc;
          order.push_back(k);
        end
        if (act_v[k] && rsp_ready[k]) begin
          hs_cnt[k]++;
          hs_cyc[k]  = cyc;
          hs_data[k] = act_d[k];
          if (k == 0) hs0_q.push_back(cyc);
        end
      end
      if (m_busy && m_age >= 2 && rsp_ready[m_owner]) m_busy = 0;
      else if (m_busy) m_age++;
      for (int k = 0; k < 2; k++) begin
        if (exp_rdy[k]) begin
          m_busy  = 1;
          m_owner = k;
          m_age   = 1;
          m_last  = k;
          m_res   = ref_res(req_op[k], req_a[k], req_b[k]);
        end
      end
    end
  end

  task automatic new_rand(input int k);
    logic [W-1:0] a;
    a = $urandom;
    req_op[k] = 3'($urandom_range(0, 7));
    req_a[k]  = a;
    case ($urandom_range(0, 3))
      0:       req_b[k] = a;
      1:       req_b[k] = 32'h8000_0000;
      2:       req_b[k] = ~a;
      default: req_b[k] = $urandom;
    endcase
    req_valid[k] = 1'b1;
  endtask

  // One driver step: after an accept either present a fresh request or go quiet.
  task automatic step(input bit renew);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (acc_pend[k]) begin
        acc_pend[k] = 0;
        if (renew) new_rand(k);
        else req_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && req_valid != 0; i++) step(0);
    if (req_valid != 0) timeout("drain");
    rsp_ready = 2'b11;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int k, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input string nm);
    int  h0;
    bit  done;
    h0 = hs_cnt[k];
    acc_pend[k] = 0;
    @(posedge clk);
    #1;
    req_op[k] = op;
    req_a[k]  = a;
    req_b[k]  = b;
    req_valid[k] = 1'b1;
    rsp_ready[k] = 1'b1;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(0);
      if (hs_cnt[k] != h0) done = 1;
    end
    if (!done) timeout(nm);
    else begin
      check(nm, hs_data[k], exp);
      check({nm, "_latency"}, W'(hs_cyc[k] - acc_cyc[k]), 2);
    end
  endtask

  initial begin
    logic [W-1:0] held;
    bit           ok;
    int           h0, s0;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    for (int k = 0; k < 2; k++) begin
      req_op[k] = '0;
      req_a[k]  = '0;
      req_b[k]  = '0;
    end

    // Contention straight out of reset: strict alternation starting with requester 0.
    new_rand(0);
    new_rand(1);
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    order.delete();
    for (int i = 0; i < 80 && order.size() < 8; i++) step(1);
    if (order.size() < 8) timeout("contention");
    else for (int i = 0; i < 8; i++) check("contention_order", W'(order[i]), W'(i % 2));
    drain();

    // Directed arithmetic with literal answers.
    run_op(0, 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, "add_wrap");
    run_op(1, 3'b010, 32'hFFFF_FFFF, 32'h1, 32'h1, "slt_neg");
    run_op(1, 3'b011, 32'hFFFF_FFFF, 32'h1, 32'h0, "sltu_big");
    run_op(0, 3'b100, 32'h1234, 32'h1234, 32'h1, "eq_same");
    run_op(1, 3'b001, 32'h3, 32'h5, 32'hFFFF_FFFE, "sub_neg");
    run_op(0, 3'b110, 32'hDEAD, 32'hBEEF, 32'h0, "illegal_op");
    run_op(1, 3'b010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, "slt_minmax");

    // Backpressure on requester 0 while requester 1 waits.
    acc_pend[0] = 0;
    acc_pend[1] = 0;
    @(posedge clk);
    #1;
    rsp_ready = 2'b10;
    req_op[0] = 3'b001; req_a[0] = 32'd100; req_b[0] = 32'd58; req_valid[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (acc_pend[0]) begin
        acc_pend[0] = 0;
        req_valid[0] = 1'b0;
        req_op[1] = 3'b000; req_a[1] = 32'd1; req_b[1] = 32'd2; req_valid[1] = 1'b1;
      end
      ok = rsp0_valid;
    end
    if (!ok) timeout("bp_rsp0");
    held = rsp0_data;
    check("bp_value", held, 32'd42);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", W'(rsp0_valid), 1);
      check("bp_data_stable", rsp0_data, held);
      check("bp_req1_blocked", W'(req1_ready), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 2'b11;
    h0 = hs_cnt[1];
    for (int i = 0; i < 20 && hs_cnt[1] == h0; i++) step(0);
    if (hs_cnt[1] == h0) timeout("bp_req1_served");
    else check("bp_req1_result", hs_data[1], 32'd3);
    drain();

    // Throughput with requester 0 streaming ADDs.
    acc_pend[0] = 0;
    @(posedge clk);
    #1;
    hs0_q.delete();
    req_op[0] = 3'b000; req_a[0] = 32'd5; req_b[0] = 32'd6; req_valid[0] = 1'b1;
    for (int i = 0; i < 60 && hs0_q.size() < 6; i++) begin
      step(0);
      if (!req_valid[0]) begin
        req_op[0] = 3'b000; req_a[0] = $urandom; req_b[0] = $urandom; req_valid[0] = 1'b1;
      end
    end
    if (hs0_q.size() < 6) timeout("throughput");
    else for (int i = 1; i < 6; i++)
      check("throughput_gap", W'(hs0_q[i] - hs0_q[i-1]), Fast ? 2 : 3);
    drain();

    // Reset while the operation is in EXEC: dropped, nothing emitted after release.
    acc_pend[1] = 0;
    @(posedge clk);
    #1;
    req_op[1] = 3'b000; req_a[1] = 32'd9; req_b[1] = 32'd9; req_valid[1] = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = acc_pend[1];
    end
    if (!ok) timeout("rst_exec_accept");
    acc_pend[1] = 0;
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_exec_ready", W'({req1_ready, req0_ready}), 0);
    check("rst_exec_valid", W'({rsp1_valid, rsp0_valid}), 0);
    check("rst_exec_data0", rsp0_data, 0);
    check("rst_exec_data1", rsp1_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s0 = rsp_seen;
    repeat (6) @(posedge clk);
    #1;
    check("rst_exec_no_rsp", W'(rsp_seen - s0), 0);

    // Randomized traffic checked cycle by cycle by the model.
    acc_pend[0] = 0;
    acc_pend[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (acc_pend[k]) begin
          acc_pend[k] = 0;
          if ($urandom_range(0, 3) != 0) new_rand(k);
          else req_valid[k] = 1'b0;
        end else if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          new_rand(k);
        end
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
    end
    rsp_ready = 2'b11;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
